// File: rtl/operand_fetch_pkg.sv
// Operand fetch shared types and field positions.
// Widths, register index type and the issued bundle layout.
package operand_fetch_pkg;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int RAW   = 5;

  localparam int RD_LSB  = 7;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  typedef logic [RAW-1:0] reg_idx_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic            rd_we;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
  } of_ex_t;

  function automatic reg_idx_t rs1_of(
    input logic [31:0] i
  );
    return i[RS1_LSB +: RAW];
  endfunction

  function automatic reg_idx_t rs2_of(
    input logic [31:0] i
  );
    return i[RS2_LSB +: RAW];
  endfunction

  function automatic reg_idx_t rd_of(
    input logic [31:0] i
  );
    return i[RD_LSB +: RAW];
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Operand fetch bus: upstream/downstream handshakes,
// register-file read port and the writeback port.
interface operand_fetch_if;
  import operand_fetch_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            in_rd_we;

  reg_idx_t        ra1;
  reg_idx_t        ra2;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;

  logic            wb_we;
  reg_idx_t        wb_wa;
  logic [XLEN-1:0] wb_wd;

  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic            out_rd_we;
  logic [XLEN-1:0] out_op1;
  logic [XLEN-1:0] out_op2;

  modport master (
    output in_valid, in_instr, in_rd_we,
    output rd1, rd2,
    output wb_we, wb_wa, wb_wd,
    output out_ready,
    input  in_ready, ra1, ra2,
    input  out_valid, out_instr, out_rd_we,
    input  out_op1, out_op2
  );

  modport slave (
    input  in_valid, in_instr, in_rd_we,
    input  rd1, rd2,
    input  wb_we, wb_wa, wb_wd,
    input  out_ready,
    output in_ready, ra1, ra2,
    output out_valid, out_instr, out_rd_we,
    output out_op1, out_op2
  );

endinterface

// File: rtl/operand_fetch_reg_scoreboard.sv
// Per-register pending bits for in-flight writers.
// Register 0 is never pending; a set beats a clear.
module reg_scoreboard
  import operand_fetch_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     set_en,
  input  reg_idx_t set_idx,
  input  logic     clr_en,
  input  reg_idx_t clr_idx,
  input  reg_idx_t q1_idx,
  input  reg_idx_t q2_idx,
  output logic     q1_pend,
  output logic     q2_pend
);

  logic [NREGS-1:0] pend;

  // update pending bits; a same-edge set overrides clear
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (i == 0)
          pend[i] <= 1'b0;
        else if (set_en && set_idx == reg_idx_t'(i))
          pend[i] <= 1'b1;
        else if (clr_en && clr_idx == reg_idx_t'(i))
          pend[i] <= 1'b0;
      end
    end
  end

  assign q1_pend = pend[q1_idx];
  assign q2_pend = pend[q2_idx];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: scoreboard hazard check and operand register.
// OPERAND_FETCH_BYPASS_EN forwards same-cycle writeback data.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  operand_fetch_if.slave       bus
);

  reg_idx_t        rs1;
  reg_idx_t        rs2;
  reg_idx_t        rd;
  logic            pend1;
  logic            pend2;
  logic            byp1;
  logic            byp2;
  logic            hazard;
  logic            accept;
  logic            set_en;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            valid_q;
  of_ex_t          q;

  assign rs1 = rs1_of(bus.in_instr);
  assign rs2 = rs2_of(bus.in_instr);
  assign rd  = rd_of(bus.in_instr);

  assign bus.ra1 = rs1;
  assign bus.ra2 = rs2;

`ifdef OPERAND_FETCH_BYPASS_EN
  assign byp1 = bus.wb_we
              && bus.wb_wa != '0
              && bus.wb_wa == rs1;
  assign byp2 = bus.wb_we
              && bus.wb_wa != '0
              && bus.wb_wa == rs2;
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  reg_scoreboard u_sb (
    .clk     (clk),
    .reset   (reset),
    .set_en  (set_en),
    .set_idx (rd),
    .clr_en  (bus.wb_we),
    .clr_idx (bus.wb_wa),
    .q1_idx  (rs1),
    .q2_idx  (rs2),
    .q1_pend (pend1),
    .q2_pend (pend2)
  );

  assign hazard = (rs1 != '0 && pend1 && !byp1)
               || (rs2 != '0 && pend2 && !byp2);

  assign bus.in_ready = !reset && !hazard
                     && (!valid_q || bus.out_ready);

  assign accept = bus.in_valid && bus.in_ready;
  assign set_en = accept && bus.in_rd_we && rd != '0;

  // select operand 1: zero register, bypass, then file
  always_comb begin
    op1 = bus.rd1;
    unique case (1'b1)
      (rs1 == '0): op1 = '0;
      byp1:        op1 = bus.wb_wd;
      default:     op1 = bus.rd1;
    endcase
  end

  // select operand 2: zero register, bypass, then file
  always_comb begin
    op2 = bus.rd2;
    unique case (1'b1)
      (rs2 == '0): op2 = '0;
      byp2:        op2 = bus.wb_wd;
      default:     op2 = bus.rd2;
    endcase
  end

  // output bundle: load on accept, drop when consumed
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      q       <= '0;
    end else if (accept) begin
      valid_q  <= 1'b1;
      q.instr  <= bus.in_instr;
      q.rd_we  <= bus.in_rd_we;
      q.op1    <= op1;
      q.op2    <= op2;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_instr = q.instr;
  assign bus.out_rd_we = q.rd_we;
  assign bus.out_op1   = q.op1;
  assign bus.out_op2   = q.op2;

endmodule
